controlled_down_counter: RTL

//  Loadable WIDTH-bit down-counter. It is the decrement-side counterpart of the

---
 rtl/controlled_down_counter.sv | 98 +++++++++
 1 files changed

// File: rtl/controlled_down_counter.sv
// Loadable down-counter with a valid/ready load port and a held done handshake.
// Each accepted decrement subtracts 1 through an explicit ripple-borrow chain;
// elapsed counts the decrements accepted since the last load.
module controlled_down_counter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_elapsed,
    output logic             o_done_valid,
    input  logic             i_done_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } state_e;

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_elapsed;
    logic [WIDTH-1:0] w_count_dec;
    logic [WIDTH-1:0] w_elapsed_inc;

    // Ripple-borrow subtract of 1: a borrow enters bit 0 and travels up through the zero bits.
    always_comb begin
        logic v_borrow;
        v_borrow    = 1'b1;
        w_count_dec = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_count_dec[i] = r_count[i] ^ v_borrow;
            v_borrow       = ~r_count[i] & v_borrow;
        end
    end

    // Elapsed wraps mod 2^WIDTH, but it never exceeds the loaded value.
    always_comb begin
        w_elapsed_inc = r_elapsed + One;
    end

    // Control FSM with the count and elapsed registers; reset is synchronous.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_count   <= '0;
            r_elapsed <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_count   <= i_load_val;
                        r_elapsed <= '0;
                        r_state   <= (i_load_val == '0) ? StDone : StCount;
                    end
                end
                StCount: begin
                    // Abort wins over dec and leaves count/elapsed where they stand.
                    if (i_abort) begin
                        r_state <= StIdle;
                    end else if (i_dec) begin
                        r_count   <= w_count_dec;
                        r_elapsed <= w_elapsed_inc;
                        if (r_count == One) begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Count is already 0 here, and dec is ignored so it cannot underflow.
                    if (i_done_ready || i_abort) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Handshake flags decode directly from the state register.
    always_comb begin
        o_in_ready   = (r_state == StIdle);
        o_done_valid = (r_state == StDone);
        o_count      = r_count;
        o_elapsed    = r_elapsed;
    end

endmodule
